// File: rtl/tt_characterizer_if.sv
// Bundle between the truth-table characterizer, the gate under test
// and the result consumer.
interface tt_characterizer_if #(
  parameter int N_IN = 4
);
  localparam int TT_W = 1 << N_IN;

  logic            start;
  logic [TT_W-1:0] exp_tt;
  logic            busy;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            tt_valid;
  logic            tt_ready;
  logic [TT_W-1:0] tt_word;
  logic            match;
  logic [N_IN-1:0] diff_idx;

  // Environment side: requester, gate under test and result consumer.
  modport master (
    output start, exp_tt, dut_out, tt_ready,
    input  busy, dut_in, tt_valid, tt_word, match, diff_idx
  );

  modport slave (
    input  start, exp_tt, dut_out, tt_ready,
    output busy, dut_in, tt_valid, tt_word, match, diff_idx
  );
endinterface

// File: rtl/tt_characterizer.sv
// Sweeps every input vector into a combinational gate, samples its response
// after SETTLE extra cycles and compares the assembled truth table.
module tt_characterizer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_characterizer_if.slave  bus
);
  localparam int TT_W  = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t          state, state_next;
  logic [N_IN-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [TT_W-1:0] exp_q, tt_word, tt_next, diff_vec;
  logic            match_q, match_next;
  logic [N_IN-1:0] diff_q, diff_next;
  logic            last, settle_done;

  assign last        = &idx;
  assign settle_done = (int'(cnt) == SETTLE - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (SETTLE == 0) ? SAMPLE : APPLY;
      APPLY:   if (settle_done) state_next = SAMPLE;
      SAMPLE:  if (last) state_next = DONE;
               else      state_next = (SETTLE == 0) ? SAMPLE : APPLY;
      DONE:    if (bus.tt_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == APPLY) || (state == SAMPLE);
    bus.tt_valid = (state == DONE);
  end

  // Compare against the word as it will look after this sample, so the
  // result is registered on the same edge that enters DONE.
  always_comb begin
    tt_next      = tt_word;
    tt_next[idx] = bus.dut_out;
    diff_vec     = tt_next ^ exp_q;
    match_next   = (diff_vec == '0);
    diff_next    = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff_vec[i]) diff_next = N_IN'(i);
    end
  end

  // idx doubles as the registered dut_in: it is cleared on the final sample,
  // so the gate sees 0 in DONE and IDLE without any output mux.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      idx     <= '0;
      cnt     <= '0;
      exp_q   <= '0;
      tt_word <= '0;
      match_q <= 1'b0;
      diff_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q   <= bus.exp_tt;
            tt_word <= '0;
            idx     <= '0;
            cnt     <= '0;
            match_q <= 1'b0;
            diff_q  <= '0;
          end
        end
        APPLY: begin
          cnt <= settle_done ? '0 : cnt + 1'b1;
        end
        SAMPLE: begin
          tt_word <= tt_next;
          if (last) begin
            idx     <= '0;
            match_q <= match_next;
            diff_q  <= diff_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in   = idx;
  assign bus.tt_word  = tt_word;
  assign bus.match    = match_q;
  assign bus.diff_idx = diff_q;
endmodule

// File: tb/tb_tt_characterizer.sv
// Scoreboard bench for tt_characterizer: three instances (SETTLE 2, 0, 1)
// driving behavioural gates, results checked against a reference model.
module tb_tt_characterizer;
  localparam int N_IN = 4;
  localparam int TT_W = 16;

  typedef struct {
    logic [TT_W-1:0] word;
    logic            match;
    logic [N_IN-1:0] diff;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tt_ready = 1'b0;
  logic [TT_W-1:0] exp_tt = '0;
  int sel = 0;
  int mode = 0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tt_characterizer_if #(.N_IN(N_IN)) if0 ();
  tt_characterizer_if #(.N_IN(N_IN)) if1 ();
  tt_characterizer_if #(.N_IN(N_IN)) if2 ();

  tt_characterizer #(.N_IN(N_IN), .SETTLE(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  tt_characterizer #(.N_IN(N_IN), .SETTLE(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  tt_characterizer #(.N_IN(N_IN), .SETTLE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [N_IN-1:0] din_a   [3];
  logic            dev_out [3];
  logic            dreg    [3];
  logic            busy_a  [3];
  logic            valid_a [3];
  logic [TT_W-1:0] word_a  [3];
  logic            match_a [3];
  logic [N_IN-1:0] diff_a  [3];

  assign if0.start = start && (sel == 0);
  assign if1.start = start && (sel == 1);
  assign if2.start = start && (sel == 2);
  assign if0.exp_tt = exp_tt;
  assign if1.exp_tt = exp_tt;
  assign if2.exp_tt = exp_tt;
  assign if0.tt_ready = tt_ready;
  assign if1.tt_ready = tt_ready;
  assign if2.tt_ready = tt_ready;
  assign if0.dut_out = dev_out[0];
  assign if1.dut_out = dev_out[1];
  assign if2.dut_out = dev_out[2];

  assign din_a[0] = if0.dut_in;   assign din_a[1] = if1.dut_in;   assign din_a[2] = if2.dut_in;
  assign busy_a[0] = if0.busy;    assign busy_a[1] = if1.busy;    assign busy_a[2] = if2.busy;
  assign valid_a[0] = if0.tt_valid; assign valid_a[1] = if1.tt_valid; assign valid_a[2] = if2.tt_valid;
  assign word_a[0] = if0.tt_word; assign word_a[1] = if1.tt_word; assign word_a[2] = if2.tt_word;
  assign match_a[0] = if0.match;  assign match_a[1] = if1.match;  assign match_a[2] = if2.match;
  assign diff_a[0] = if0.diff_idx; assign diff_a[1] = if1.diff_idx; assign diff_a[2] = if2.diff_idx;

  // Gate models: 0 = in[0], 1 = AND4, 2 = parity, 3 = in[0] through one flop.
  function automatic logic gate_f(input int m, input logic [N_IN-1:0] v);
    case (m)
      1:       return &v;
      2:       return ^v;
      default: return v[0];
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dev
    always @(posedge clk) dreg[k] <= din_a[k][0];
    assign dev_out[k] = (mode == 3) ? dreg[k] : gate_f(mode, din_a[k]);
  end

  function automatic int settle_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 0 : 1;
  endfunction

  // With no settle time the flopped gate still shows the previous vector.
  function automatic logic [TT_W-1:0] model_word(input int m, input int st);
    logic [TT_W-1:0] w;
    logic [N_IN-1:0] v;
    w = '0;
    for (int i = 0; i < TT_W; i++) begin
      v = N_IN'(i);
      if (m == 3 && st == 0) v = (i == 0) ? '0 : N_IN'(i - 1);
      w[i] = gate_f(m, v);
    end
    return w;
  endfunction

  function automatic logic [N_IN-1:0] lowest_set(input logic [TT_W-1:0] x);
    for (int i = 0; i < TT_W; i++) if (x[i]) return N_IN'(i);
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sweep(input int s, input int m, input logic [TT_W-1:0] e,
                       input bit poke, input int hold, input bit start_w_ready);
    int st, cyc;
    exp_t x, got;
    st = settle_of(s);
    sel = s;
    mode = m;
    x.word  = model_word(m, st);
    x.match = (x.word == e);
    x.diff  = lowest_set(x.word ^ e);
    x.lat   = TT_W * (st + 1);
    sb.push_back(x);

    @(negedge clk);
    exp_tt = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_tt = ~e;
    cyc = 0;
    while (!valid_a[sel] && cyc <= x.lat + 8) begin
      check("dut_in", 32'(din_a[sel]), 32'(cyc / (st + 1)));
      check("busy", 32'(busy_a[sel]), 32'd1);
      start = (poke && cyc == 4);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(x.lat));
    if (!valid_a[sel]) return;

    got = sb.pop_front();
    check("tt_word", 32'(word_a[sel]), 32'(got.word));
    check("match", 32'(match_a[sel]), 32'(got.match));
    check("diff_idx", 32'(diff_a[sel]), 32'(got.diff));
    check("done_busy", 32'(busy_a[sel]), 32'd0);
    check("done_dut_in", 32'(din_a[sel]), 32'd0);

    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(valid_a[sel]), 32'd1);
      check("hold_word", 32'(word_a[sel]), 32'(got.word));
    end

    tt_ready = 1'b1;
    start = start_w_ready;
    tick();
    tt_ready = 1'b0;
    start = 1'b0;
    check("ack_valid", 32'(valid_a[sel]), 32'd0);
    check("ack_busy", 32'(busy_a[sel]), 32'd0);
    tick();
    check("idle_busy", 32'(busy_a[sel]), 32'd0);
    check("retained_word", 32'(word_a[sel]), 32'(got.word));
  endtask

  task automatic abort_sweep();
    int n;
    bit seen;
    sel = 0;
    mode = 0;
    @(negedge clk);
    exp_tt = 16'hAAAA;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (din_a[0] != 4'd7 && n < 40) begin
      tick();
      n++;
    end
    check("reach_vec7", 32'(din_a[0]), 32'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_busy", 32'(busy_a[0]), 32'd0);
    check("rst_dut_in", 32'(din_a[0]), 32'd0);
    check("rst_word", 32'(word_a[0]), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (valid_a[0]) seen = 1'b1;
      tick();
    end
    check("rst_no_valid", 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(busy_a[0]), 32'd0);
    check("reset_valid", 32'(valid_a[0]), 32'd0);
    check("reset_dut_in", 32'(din_a[0]), 32'd0);
    check("reset_word", 32'(word_a[0]), 32'd0);
    check("reset_match", 32'(match_a[0]), 32'd0);
    check("reset_diff", 32'(diff_a[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    sweep(0, 0, 16'hAAAA, 1'b0, 0, 1'b0);
    sweep(0, 1, 16'h8001, 1'b0, 10, 1'b0);
    sweep(1, 2, 16'h6996, 1'b0, 0, 1'b0);
    sweep(1, 3, 16'hAAAA, 1'b0, 0, 1'b0);
    sweep(2, 3, 16'hAAAA, 1'b0, 0, 1'b0);
    abort_sweep();
    sweep(0, 2, 16'h6996, 1'b0, 0, 1'b0);
    sweep(0, 0, 16'hAAAA, 1'b1, 2, 1'b1);
    sweep(0, 1, 16'h8000, 1'b0, 0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
